// File: rtl/ecc_result_pkg.sv
// Shared codes and entry sizing for the ECC result FIFO.
package ecc_result_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ONE  = 2'b01;
  localparam logic [1:0] ERR_TWO  = 2'b10;

  localparam logic [1:0] MODE_ENC = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_FC  = 2'b10;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ENTRY_W        = DATA_WIDTH_DEF + 4;

  // Entry = {op_mode, num_of_errors, data}
  function automatic int unsigned entry_w(int unsigned data_width);
    return data_width + 4;
  endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ecc_sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ecc_result_fifo.sv
// Captures ECC core results on operation_done rising edges into a FWFT valid/ready FIFO.
// Optional per-class error statistics are built when ECC_RES_STATS_EN is defined.
module ecc_result_fifo
  import ecc_result_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  input  logic [1:0]                 op_mode,
  input  logic                       clear,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic [1:0]                 res_mode,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       cnt_clean,
  output logic [CNT_WIDTH-1:0]       cnt_corr,
  output logic [CNT_WIDTH-1:0]       cnt_uncorr
);

  localparam int unsigned ADDR = $clog2(DEPTH);
  localparam int unsigned EW   = entry_w(DATA_WIDTH);

  logic              done_q;
  logic              capture;
  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR-1:0]   wr_ptr_q;
  logic [ADDR-1:0]   rd_ptr_q;
  logic [ADDR-1:0]   rd_ptr_d;
  logic [ADDR:0]     count_q;
  logic [ADDR:0]     count_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     head_q;
  logic [EW-1:0]     head_d;
  logic [EW-1:0]     new_entry;
  logic              overflow_q;

  assign capture   = operation_done & ~done_q;
  assign full      = (count_q == (ADDR+1)'(DEPTH));
  assign res_valid = (count_q != '0);
  assign pop       = res_valid & res_ready;
  assign push      = capture & (~full | pop);
  assign new_entry = {op_mode, num_of_errors, data_out};

  always_comb begin
    rd_ptr_d = rd_ptr_q + ADDR'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    head_d = head_q;
    // New entry goes straight to the head register when nothing else remains ahead of it
    if (push && ((count_q == '0) || (pop && (count_q == (ADDR+1)'(1))))) begin
      head_d = new_entry;
    end else if (pop) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // done_q keeps tracking through clear so a held level never re-captures
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= operation_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (capture && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign {res_mode, res_errors, res_data} = head_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef ECC_RES_STATS_EN
  logic stat_cap;
  assign stat_cap = capture & (op_mode != MODE_ENC);

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_clean (
    .clk (clk),
    .rst (rst),
    .inc (stat_cap && (num_of_errors == ERR_NONE)),
    .clr (clear),
    .cnt (cnt_clean)
  );

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_corr (
    .clk (clk),
    .rst (rst),
    .inc (stat_cap && (num_of_errors == ERR_ONE)),
    .clr (clear),
    .cnt (cnt_corr)
  );

  ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_uncorr (
    .clk (clk),
    .rst (rst),
    .inc (stat_cap && (num_of_errors[1] == ERR_TWO[1])),
    .clr (clear),
    .cnt (cnt_uncorr)
  );
`else
  assign cnt_clean  = '0;
  assign cnt_corr   = '0;
  assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_ecc_result_fifo.sv
// Randomized bench for ecc_result_fifo against a queue-based reference model.
module tb_ecc_result_fifo;
  import ecc_result_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_out = '0;
  logic        operation_done = 1'b0;
  logic [1:0]  num_of_errors = '0;
  logic [1:0]  op_mode = '0;
  logic        clear = 1'b0;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic [1:0]  res_mode;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] cnt_clean;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;

  ecc_result_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors),
    .op_mode        (op_mode),
    .clear          (clear),
    .res_data       (res_data),
    .res_errors     (res_errors),
    .res_mode       (res_mode),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .cnt_clean      (cnt_clean),
    .cnt_corr       (cnt_corr),
    .cnt_uncorr     (cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  m;
    logic [1:0]  e;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_prev_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_clean = '0;
  logic [15:0] m_corr = '0;
  logic [15:0] m_uncorr = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef ECC_RES_STATS_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  task automatic compare_all();
    check("valid", 64'(res_valid), 64'(mq.size() > 0));
    check("count", 64'(fifo_count), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() > 0) begin
      check("head_data", 64'(res_data), 64'(mq[0].d));
      check("head_err", 64'(res_errors), 64'(mq[0].e));
      check("head_mode", 64'(res_mode), 64'(mq[0].m));
    end
    check("cnt_clean", 64'(cnt_clean), 64'(exp_cnt(m_clean)));
    check("cnt_corr", 64'(cnt_corr), 64'(exp_cnt(m_corr)));
    check("cnt_uncorr", 64'(cnt_uncorr), 64'(exp_cnt(m_uncorr)));
  endtask

  // One clock: model computes from the inputs presented at the edge.
  task automatic cycle();
    logic cap;
    logic pp;
    int   sz;
    cap = operation_done & ~m_prev_done;
    pp  = (mq.size() > 0) & res_ready;
    sz  = mq.size();
    @(posedge clk);
    #1;
    m_prev_done = operation_done;
    if (clear) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_clean  = '0;
      m_corr   = '0;
      m_uncorr = '0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (cap) begin
        if (sz < DEPTH || pp) mq.push_back({op_mode, num_of_errors, data_out});
        else m_ovf = 1'b1;
        if (op_mode != MODE_ENC) begin
          if (num_of_errors == ERR_NONE) m_clean = (m_clean == 16'hFFFF) ? m_clean : m_clean + 1;
          else if (num_of_errors == ERR_ONE) m_corr = (m_corr == 16'hFFFF) ? m_corr : m_corr + 1;
          else m_uncorr = (m_uncorr == 16'hFFFF) ? m_uncorr : m_uncorr + 1;
        end
      end
    end
    compare_all();
  endtask

  task automatic drive(input logic done, input logic [31:0] d, input logic [1:0] e,
                       input logic [1:0] m, input logic rdy, input logic clr);
    operation_done = done;
    data_out       = d;
    num_of_errors  = e;
    op_mode        = m;
    res_ready      = rdy;
    clear          = clr;
    cycle();
  endtask

  task automatic pulse(input logic rdy);
    drive(1'b1, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rdy, 1'b0);
    drive(1'b0, $urandom, 2'b00, 2'b00, rdy, 1'b0);
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_count"}, 64'(fifo_count), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_data"}, 64'(res_data), 64'd0);
    check({tag, "_err"}, 64'(res_errors), 64'd0);
    check({tag, "_mode"}, 64'(res_mode), 64'd0);
    check({tag, "_cnt"}, 64'({cnt_clean, cnt_corr, cnt_uncorr}), 64'd0);
    mq.delete();
    m_prev_done = 1'b0;
    m_ovf       = 1'b0;
    m_clean     = '0;
    m_corr      = '0;
    m_uncorr    = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #3;
    do_reset("rst0");

    // Mid-stream reset with done held high: capture restarts after release.
    for (int i = 0; i < 3; i++) pulse(1'b0);
    operation_done = 1'b1;
    op_mode        = MODE_DEC;
    do_reset("rst_mid");
    drive(1'b1, 32'h1234_5678, ERR_NONE, MODE_DEC, 1'b0, 1'b0);
    drive(1'b1, 32'h0, ERR_NONE, MODE_DEC, 1'b0, 1'b0);
    check("rst_mid_recapture", 64'(fifo_count), 64'd1);

    // Held level produces exactly one capture.
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hDEAD_BEEF, ERR_ONE, MODE_DEC, 1'b0, 1'b0);
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b0);
    check("t2_count", 64'(fifo_count), 64'd1);
    check("t2_data", 64'(res_data), 64'hDEAD_BEEF);
    check("t2_cnt_corr", 64'(cnt_corr), 64'(exp_cnt(16'd1)));

    // Overflow on the ninth capture, then drain in order.
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) pulse(1'b0);
    check("t3_count", 64'(fifo_count), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b1, 1'b0);
    check("t3_empty", 64'(fifo_count), 64'd0);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous capture and pop.
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pulse(1'b0);
    drive(1'b1, 32'hCAFE_F00D, ERR_TWO, MODE_FC, 1'b1, 1'b0);
    check("t4_count", 64'(fifo_count), 64'd8);
    check("t4_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 9; i++) drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b1, 1'b0);

    // Captures every two cycles with toggling ready.
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      drive(1'((i % 2) == 0), $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'((i % 4) < 2), 1'b0);
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b1, 1'b0);

    // Clear coincident with capture at count 3.
    drive(1'b0, 32'h0, ERR_NONE, MODE_ENC, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b0);
    drive(1'b1, 32'hAAAA_5555, ERR_ONE, MODE_DEC, 1'b0, 1'b1);
    check("t6_count", 64'(fifo_count), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    check("t6_cnt", 64'({cnt_clean, cnt_corr, cnt_uncorr}), 64'd0);
    drive(1'b1, 32'hAAAA_5555, ERR_ONE, MODE_DEC, 1'b0, 1'b0);
    check("t6_no_recapture", 64'(fifo_count), 64'd0);

    // Random traffic with rare clears and one asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rst_rand");
      drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
